adc_timebase_gen: RTL and testbench
===================================

// Module: adc_timebase_gen
// PURPOSE
//  Programmable ADC sample-clock generator for the scope time base; parametrised successor to the fixed 8-bit divider.
//  Divides clk50 by a power-of-two or a custom ratio and changes ratio glitch-free at period boundaries.
//  Also provides a one-cycle sample strobe and a burst mode that stops after N samples.
//  Sits between the front-panel time-base control and the ADC/capture-memory write logic.
// PARAMETERS
//  CNT_W      16    half-period counter width; max half-period 2^CNT_W-1 clk50 cycles
//  BASE_W     4     width of base select
//  LEN_W      16    width of burst length / sample counter
//  IDLE_LEVEL 1'b1  ADC_clk level driven while idle
// PORTS
//  clk50        in   1       system clock, 50 MHz
//  rst          in   1       asynchronous reset, active-high
//  enable       in   1       run permission; low requests a clean stop
//  start        in   1       pulse: begin generating (IDLE only)
//  load         in   1       pulse: capture new ratio from base/custom_en/custom_half
//  base         in   BASE_W  power-of-two select: H = 2<<base
//  custom_en    in   1       1: H = custom_half instead of base
//  custom_half  in   CNT_W   custom half-period in clk50 cycles (0 treated as 1)
//  burst_len    in   LEN_W   samples per burst; 0 = continuous
//  ADC_clk      out  1       ADC sample clock, period 2*H clk50 cycles
//  sample_stb   out  1       1-cycle pulse coincident with each ADC_clk rise
//  ratio_ack    out  1       1-cycle pulse when a loaded ratio takes effect
//  busy         out  1       high in RUN and STOPPING
//  done         out  1       1-cycle pulse when a burst completes
// BEHAVIOUR
//  Reset: state IDLE, ADC_clk=IDLE_LEVEL, sample_stb/ratio_ack/busy/done=0, counters 0, active and pending H=2.
//  All outputs are registered. H saturates to 2^CNT_W-1 if 2<<base overflows CNT_W bits.
//  States: IDLE -> RUN on (start & enable): counter=0, ADC_clk=0, sample count=0, busy=1 next cycle.
//   RUN: counter counts 0..H-1; at H-1 counter=0 and ADC_clk toggles. Toggle 0->1 also pulses sample_stb
//     and increments the sample count.
//   RUN -> STOPPING when enable=0, or when burst_len!=0 and the sample_stb that reaches burst_len is issued.
//   STOPPING: keep counting; at the next 1->0 toggle go to IDLE, ADC_clk=IDLE_LEVEL next cycle, busy=0.
//     done pulses in that cycle only if the stop was a burst completion. No sample_stb in STOPPING.
//   If STOPPING is entered while ADC_clk=0 (enable drop in low half), the low half completes, then IDLE.
//     No further rise occurs.
//  Ratio update: load captures inputs into the pending register.
//   RUN/STOPPING: pending is applied only at a 1->0 toggle (full-period boundary), with ratio_ack that cycle.
//     Half-periods are therefore never truncated.
//   load in the same cycle as the apply point: the new inputs are applied directly (load wins).
//   IDLE: applied the cycle after load, with ratio_ack.
//   Multiple loads before the apply point: the last one wins, with one ratio_ack.
//  start while busy is ignored. start with enable=0 is ignored.
//  enable=0 in IDLE: no effect.
//  burst_len is sampled at start; changes mid-burst are ignored.
//  rst mid-operation: immediate return to the reset state; no done pulse.
// TESTING
//  1 base=0, start, burst_len=0 -> ADC_clk period 4 clk50 (12.5 MHz).
//    First rise 2 cycles after RUN entry; sample_stb every 4 cycles.
//  2 base=7 -> H=256, period 512 cycles. custom_en=1, custom_half=0 -> H=1, period 2 cycles.
//    base=15, CNT_W=16 -> H saturates at 65535.
//  3 Running at base=2 (H=8); load base=0 mid high-half -> the old 16-cycle period completes.
//    ratio_ack pulses at the falling edge, then period 4.
//  4 burst_len=5, base=1 -> exactly 5 sample_stb pulses.
//    done pulses once after the 5th period's fall; busy=0, ADC_clk=IDLE_LEVEL afterwards.
//  5 Drop enable during the low half, then during the high half.
//    Low: no extra rise. High: that period completes. done stays 0 in both cases.
//  6 Assert rst mid-burst, and start while busy.
//    rst: outputs return to reset values immediately. start while busy: ignored, no restart.

Source files
------------

// File: rtl/adc_timebase_gen.sv
// adc_timebase_gen: programmable ADC sample-clock divider (clk50/rst in; enable/start/load/base/custom_en/custom_half/burst_len in; ADC_clk/sample_stb/ratio_ack/busy/done out) with glitch-free ratio change and burst stop
module adc_timebase_gen #(
  parameter int   CNT_W      = 16,
  parameter int   BASE_W     = 4,
  parameter int   LEN_W      = 16,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic              load,
  input  logic [BASE_W-1:0] base,
  input  logic              custom_en,
  input  logic [CNT_W-1:0]  custom_half,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              ADC_clk,
  output logic              sample_stb,
  output logic              ratio_ack,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, h_q, h_d, ph_q, ph_d, h_in, h_pow;
  logic [LEN_W-1:0] n_q, n_d, len_q, len_d;
  logic pend_q, pend_d, adc_q, adc_d, stb_q, stb_d, ack_q, ack_d;
  logic busy_q, busy_d, done_q, done_d, bst_q, bst_d;
  logic go, wrap, rise, fall, last, apply_load, apply_pend;
  assign go = start & enable;
  assign wrap = (state_q != IDLE) && (cnt_q == h_q - CNT_W'(1));
  assign rise = wrap & ~adc_q & (state_q == RUN);
  assign fall = wrap & adc_q;
  assign last = (len_q != '0) && (n_q + LEN_W'(1) == len_q);
  assign h_pow = (int'(base) > CNT_W - 2) ? '1 : CNT_W'(2) << base;
  assign h_in = custom_en ? ((custom_half == '0) ? CNT_W'(1) : custom_half) : h_pow;
  assign apply_load = load & fall;
  assign apply_pend = pend_q & ~apply_load & ((state_q == IDLE) | fall);
  always_ff @(posedge clk50 or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      h_q     <= CNT_W'(2);
      ph_q    <= CNT_W'(2);
      n_q     <= '0;
      len_q   <= '0;
      pend_q  <= 1'b0;
      adc_q   <= IDLE_LEVEL;
      stb_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      ph_q    <= ph_d;
      n_q     <= n_d;
      len_q   <= len_d;
      pend_q  <= pend_d;
      adc_q   <= adc_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bst_q   <= bst_d;
    end
  always_comb
    state_d = (state_q == IDLE) ? (go ? RUN : IDLE) :
              (state_q == RUN)  ? ((!enable || (rise && last)) ? STOPPING : RUN) :
              (wrap ? IDLE : STOPPING);
  always_comb begin
    cnt_d  = ((state_q == IDLE) || wrap) ? '0 : cnt_q + CNT_W'(1);
    adc_d  = (state_q == IDLE) ? (go ? 1'b0 : IDLE_LEVEL) :
             (state_q == STOPPING && wrap) ? IDLE_LEVEL : adc_q ^ wrap;
    stb_d  = rise;
    n_d    = (state_q == IDLE) ? '0 : rise ? n_q + LEN_W'(1) : n_q;
    len_d  = (state_q == IDLE && go) ? burst_len : len_q;
    busy_d = state_d != IDLE;
    bst_d  = (state_q == IDLE) ? 1'b0 : bst_q | (rise & last);
    done_d = (state_q == STOPPING) & wrap & bst_q;
    h_d    = apply_load ? h_in : apply_pend ? ph_q : h_q;
    ph_d   = load ? h_in : ph_q;
    pend_d = (load & ~apply_load) | (pend_q & ~apply_pend & ~apply_load);
    ack_d  = apply_load | apply_pend;
  end
  assign ADC_clk    = adc_q;
  assign sample_stb = stb_q;
  assign ratio_ack  = ack_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_adc_timebase_gen.sv
// tb_adc_timebase_gen: scoreboard bench for adc_timebase_gen
module tb_adc_timebase_gen;
  logic clk50 = 1'b0, rst = 1'b1, enable = 1'b0, start = 1'b0, load = 1'b0, custom_en = 1'b0;
  logic [3:0] base = '0;
  logic [15:0] custom_half = '0, burst_len = '0;
  logic adc, stb, ack, busy, done;
  logic s_en = 1'b0, s_start = 1'b0, s_load = 1'b0;
  logic [3:0] s_base = 4'd7;
  logic [7:0] s_half = '0;
  logic [15:0] s_len = '0;
  logic s_adc, s_stb, s_ack, s_busy, s_done;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {int kind; int at;} evt_t;
  evt_t q[$];
  always #10 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;
  adc_timebase_gen dut (
    .clk50(clk50), .rst(rst), .enable(enable), .start(start), .load(load),
    .base(base), .custom_en(custom_en), .custom_half(custom_half), .burst_len(burst_len),
    .ADC_clk(adc), .sample_stb(stb), .ratio_ack(ack), .busy(busy), .done(done)
  );
  adc_timebase_gen #(.CNT_W(8)) u_sat (
    .clk50(clk50), .rst(rst), .enable(s_en), .start(s_start), .load(s_load),
    .base(s_base), .custom_en(1'b0), .custom_half(s_half), .burst_len(s_len),
    .ADC_clk(s_adc), .sample_stb(s_stb), .ratio_ack(s_ack), .busy(s_busy), .done(s_done)
  );
  task automatic check(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask
  task automatic expect_evt(input int kind, input int at);
    evt_t e;
    e.kind = kind;
    e.at = at;
    q.push_back(e);
  endtask
  task automatic pop_evt(input int kind);
    evt_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL evt unexpected: got kind %0d at cyc %0d, expected none", kind, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.at != cyc) begin
        fails++;
        $display("FAIL evt: got kind %0d at cyc %0d, expected kind %0d at cyc %0d", kind, cyc, e.kind, e.at);
      end
    end
  endtask
  // kinds: 0 = sample_stb, 1 = ratio_ack, 2 = done
  always @(negedge clk50)
    if (!rst) begin
      if (stb) pop_evt(0);
      if (ack) pop_evt(1);
      if (done) pop_evt(2);
    end
  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk50);
  endtask
  task automatic load_idle(input logic [3:0] b, input logic ce, input logic [15:0] ch);
    base = b;
    custom_en = ce;
    custom_half = ch;
    load = 1'b1;
    @(negedge clk50);
    load = 1'b0;
    expect_evt(1, cyc + 1);
    @(negedge clk50);
  endtask
  task automatic pulse_load(input logic [3:0] b);
    base = b;
    custom_en = 1'b0;
    load = 1'b1;
    @(negedge clk50);
    load = 1'b0;
  endtask
  task automatic do_start(input logic [15:0] bl, output int k);
    enable = 1'b1;
    burst_len = bl;
    start = 1'b1;
    @(negedge clk50);
    start = 1'b0;
    k = cyc;
  endtask
  initial begin
    int k, t;
    repeat (2) @(negedge clk50);
    check("reset ADC_clk", adc, 1);
    check("reset sample_stb", stb, 0);
    check("reset ratio_ack", ack, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    rst = 1'b0;
    @(negedge clk50);
    load_idle(4'd0, 1'b0, 16'd0);
    do_start(16'd0, k);
    for (int i = 0; i < 3; i++) expect_evt(0, k + 2 + 4 * i);
    wait_to(k + 10);
    enable = 1'b0;
    wait_to(k + 11);
    check("h2 stop high busy", busy, 1);
    wait_to(k + 12);
    check("h2 stop idle busy", busy, 0);
    check("h2 stop idle level", adc, 1);
    check("h2 stop no done", done, 0);
    load_idle(4'd7, 1'b0, 16'd0);
    do_start(16'd0, k);
    expect_evt(0, k + 256);
    wait_to(k + 600);
    enable = 1'b0;
    wait_to(k + 767);
    check("h256 low stop busy", busy, 1);
    check("h256 low stop clk", adc, 0);
    wait_to(k + 768);
    check("h256 idle busy", busy, 0);
    check("h256 idle level", adc, 1);
    check("h256 no done", done, 0);
    load_idle(4'd0, 1'b1, 16'd0);
    do_start(16'd0, k);
    for (int i = 0; i < 3; i++) expect_evt(0, k + 1 + 2 * i);
    wait_to(k + 5);
    enable = 1'b0;
    wait_to(k + 6);
    check("h1 stopping busy", busy, 1);
    check("h1 stopping clk", adc, 0);
    wait_to(k + 7);
    check("h1 idle busy", busy, 0);
    check("h1 idle level", adc, 1);
    load_idle(4'd2, 1'b0, 16'd0);
    do_start(16'd0, k);
    expect_evt(0, k + 8);
    expect_evt(1, k + 16);
    expect_evt(0, k + 18);
    expect_evt(0, k + 22);
    expect_evt(1, k + 24);
    expect_evt(0, k + 28);
    expect_evt(0, k + 36);
    wait_to(k + 10);
    pulse_load(4'd3);
    wait_to(k + 12);
    pulse_load(4'd0);
    wait_to(k + 21);
    pulse_load(4'd5);
    wait_to(k + 23);
    pulse_load(4'd1);
    wait_to(k + 36);
    enable = 1'b0;
    wait_to(k + 39);
    check("ratio stop busy", busy, 1);
    wait_to(k + 40);
    check("ratio idle busy", busy, 0);
    load_idle(4'd1, 1'b0, 16'd0);
    do_start(16'd5, k);
    burst_len = 16'd2;
    for (int i = 0; i < 5; i++) expect_evt(0, k + 4 + 8 * i);
    expect_evt(2, k + 40);
    wait_to(k + 10);
    start = 1'b1;
    @(negedge clk50);
    start = 1'b0;
    wait_to(k + 39);
    check("burst busy before end", busy, 1);
    wait_to(k + 40);
    check("burst done", done, 1);
    check("burst idle busy", busy, 0);
    check("burst idle level", adc, 1);
    do_start(16'd5, k);
    expect_evt(0, k + 4);
    expect_evt(0, k + 12);
    wait_to(k + 14);
    rst = 1'b1;
    #1;
    check("rst ADC_clk", adc, 1);
    check("rst busy", busy, 0);
    check("rst sample_stb", stb, 0);
    check("rst done", done, 0);
    check("rst ratio_ack", ack, 0);
    @(negedge clk50);
    rst = 1'b0;
    @(negedge clk50);
    do_start(16'd0, k);
    expect_evt(0, k + 2);
    wait_to(k + 2);
    enable = 1'b0;
    wait_to(k + 4);
    check("post rst idle busy", busy, 0);
    s_load = 1'b1;
    @(negedge clk50);
    s_load = 1'b0;
    @(negedge clk50);
    check("sat ratio_ack", s_ack, 1);
    s_en = 1'b1;
    s_start = 1'b1;
    @(negedge clk50);
    s_start = 1'b0;
    k = cyc;
    t = -1;
    for (int i = 0; i < 600 && t < 0; i++) begin
      @(negedge clk50);
      if (s_stb) t = cyc;
    end
    check("sat first rise", t, k + 255);
    s_en = 1'b0;
    repeat (5) @(negedge clk50);
    check("scoreboard drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
